// File: rtl/watchdog_multichannel.sv
//==============================================================================
// Module   : watchdog_multichannel
// Brief    : NUM_CHANNELS independent heartbeat watchdogs with programmable
//            limits, a latched first-expired index and a shared post-timeout
//            grace countdown that raises a sticky shutdown request.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module watchdog_multichannel #(
    parameter int              NUM_CHANNELS       = 4,
    parameter int              COUNTER_WIDTH      = 64,
    parameter longint unsigned DEFAULT_TIMEOUT    = 64'd10_000_000,
    parameter int              POST_COUNTER_WIDTH = 8,
    parameter int              POST_TIMEOUT       = 100,
    localparam int             CHAN_W             = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CHANNELS-1:0]       enable,
    input  logic [NUM_CHANNELS-1:0]       kick,
    input  logic                          cfg_we,
    input  logic [CHAN_W-1:0]             cfg_channel,
    input  logic [COUNTER_WIDTH-1:0]      cfg_value,
    input  logic                          timeout_ack,
    output logic [NUM_CHANNELS-1:0]       timeout,
    output logic                          any_timeout,
    output logic [CHAN_W-1:0]             first_channel,
    output logic [POST_COUNTER_WIDTH-1:0] post_count,
    output logic                          shutdown
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam logic [COUNTER_WIDTH-1:0]      c_default_limit = COUNTER_WIDTH'(DEFAULT_TIMEOUT);
    localparam logic [COUNTER_WIDTH-1:0]      c_cnt_one       = COUNTER_WIDTH'(1);
    localparam logic [POST_COUNTER_WIDTH-1:0] c_post_reload   = POST_COUNTER_WIDTH'(POST_TIMEOUT);
    localparam logic [POST_COUNTER_WIDTH-1:0] c_post_one      = POST_COUNTER_WIDTH'(1);

    // Per-channel state encoding
    localparam logic [1:0] c_ch_idle    = 2'd0;
    localparam logic [1:0] c_ch_run     = 2'd1;
    localparam logic [1:0] c_ch_expired = 2'd2;

    // Grace state encoding
    localparam logic [1:0] c_gr_wait    = 2'd0;
    localparam logic [1:0] c_gr_count   = 2'd1;
    localparam logic [1:0] c_gr_acked   = 2'd2;
    localparam logic [1:0] c_gr_dead    = 2'd3;

    //--------------------------------------------------------------------------
    // Shared signals
    //--------------------------------------------------------------------------
    // Which channels will be expired after the coming edge; used to latch
    // first_channel on the same edge that the timeout flags rise.
    logic [NUM_CHANNELS-1:0]       w_expired_next;
    logic                          w_any_next;
    logic [CHAN_W-1:0]             w_lowest_next;
    logic [CHAN_W-1:0]             r_first;

    logic [1:0]                    r_gr_state;
    logic [1:0]                    w_gr_next;
    logic [POST_COUNTER_WIDTH-1:0] r_post;

    //--------------------------------------------------------------------------
    // Channel watchdogs
    //--------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
        logic [1:0]               r_state;
        logic [1:0]               w_state_next;
        logic [COUNTER_WIDTH-1:0] r_limit;
        logic [COUNTER_WIDTH-1:0] r_count;
        logic                     w_cfg_hit;

        // Indices at or above NUM_CHANNELS never match any channel, so such
        // writes fall on the floor without extra range logic.
        assign w_cfg_hit = cfg_we && (cfg_channel == CHAN_W'(gi));

        // Channel state register
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= c_ch_idle;
            end else begin
                r_state <= w_state_next;
            end
        end

        // Channel next-state: disable always wins, then kick beats expiry
        always_comb begin
            w_state_next = r_state;
            if (!enable[gi]) begin
                w_state_next = c_ch_idle;
            end else begin
                case (r_state)
                    c_ch_idle:    w_state_next = c_ch_run;
                    c_ch_run: begin
                        if (!kick[gi] && (r_count == '0)) begin
                            w_state_next = c_ch_expired;
                        end
                    end
                    c_ch_expired: w_state_next = c_ch_expired;
                    default:      w_state_next = c_ch_idle;
                endcase
            end
        end

        // Countdown: reload while idle or on kick, otherwise decrement to zero
        always_ff @(posedge clk) begin
            if (reset) begin
                r_count <= c_default_limit;
            end else if (!enable[gi] || (r_state == c_ch_idle)) begin
                r_count <= r_limit;
            end else if (r_state == c_ch_run) begin
                if (kick[gi]) begin
                    r_count <= r_limit;
                end else if (r_count != '0) begin
                    r_count <= r_count - c_cnt_one;
                end
            end
        end

        // Limit register; a kick on the write edge still sees the old value
        always_ff @(posedge clk) begin
            if (reset) begin
                r_limit <= c_default_limit;
            end else if (w_cfg_hit) begin
                r_limit <= cfg_value;
            end
        end

        // Flag comes straight from the state flop, so it is registered
        assign timeout[gi]        = (r_state == c_ch_expired);
        assign w_expired_next[gi] = (w_state_next == c_ch_expired);
    end : g_chan

    assign any_timeout = |timeout;
    assign w_any_next  = |w_expired_next;

    //--------------------------------------------------------------------------
    // First-expired channel
    //--------------------------------------------------------------------------
    // Lowest-index channel among those expiring on the coming edge
    always_comb begin
        w_lowest_next = '0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            if (w_expired_next[k]) begin
                w_lowest_next = CHAN_W'(k);
            end
        end
    end

    // Latch on the 0->1 transition of any_timeout, release when all clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_first <= '0;
        end else if (!w_any_next) begin
            r_first <= '0;
        end else if (!any_timeout) begin
            r_first <= w_lowest_next;
        end
    end

    assign first_channel = r_first;

    //--------------------------------------------------------------------------
    // Post-timeout grace FSM
    //--------------------------------------------------------------------------
    // Grace state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gr_state <= c_gr_wait;
        end else begin
            r_gr_state <= w_gr_next;
        end
    end

    // Grace next-state: clearing all timeouts aborts the countdown; an ack
    // arriving on the zero edge still beats the shutdown
    always_comb begin
        w_gr_next = r_gr_state;
        case (r_gr_state)
            c_gr_wait: begin
                if (any_timeout) begin
                    w_gr_next = c_gr_count;
                end
            end
            c_gr_count: begin
                if (!any_timeout) begin
                    w_gr_next = c_gr_wait;
                end else if (timeout_ack) begin
                    w_gr_next = c_gr_acked;
                end else if (r_post == '0) begin
                    w_gr_next = c_gr_dead;
                end
            end
            c_gr_acked: begin
                if (!any_timeout) begin
                    w_gr_next = c_gr_wait;
                end
            end
            c_gr_dead:  w_gr_next = c_gr_dead;
            default:    w_gr_next = c_gr_wait;
        endcase
    end

    // Grace counter: reload whenever heading to WAIT, count only while
    // COUNT persists; ACKED and DEAD freeze the value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_post <= c_post_reload;
        end else if (w_gr_next == c_gr_wait) begin
            r_post <= c_post_reload;
        end else if ((r_gr_state == c_gr_count) && (w_gr_next == c_gr_count)) begin
            r_post <= r_post - c_post_one;
        end
    end

    // Grace outputs decoded from registered state
    always_comb begin
        post_count = r_post;
        shutdown   = (r_gr_state == c_gr_dead);
    end

endmodule : watchdog_multichannel

`default_nettype wire

// File: tb/tb_watchdog_multichannel.sv
//==============================================================================
// Module   : tb_watchdog_multichannel
// Brief    : Self-checking bench for watchdog_multichannel. Directed scenarios
//            with literal expectations followed by a randomized run, all
//            compared every cycle against a behavioural reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_watchdog_multichannel;

    // Five channels so that cfg_channel is 3 bits wide and indices 5..7 are
    // genuinely out of range.
    localparam int NCH = 5;
    localparam int CW  = 16;
    localparam int DEF = 40;
    localparam int PW  = 8;
    localparam int PT  = 4;
    localparam int CHW = 3;

    // Grace phases used by the model
    localparam int P_WAIT  = 0;
    localparam int P_COUNT = 1;
    localparam int P_ACKED = 2;
    localparam int P_DEAD  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [NCH-1:0]  enable;
    logic [NCH-1:0]  kick;
    logic            cfg_we;
    logic [CHW-1:0]  cfg_channel;
    logic [CW-1:0]   cfg_value;
    logic            timeout_ack;
    logic [NCH-1:0]  timeout;
    logic            any_timeout;
    logic [CHW-1:0]  first_channel;
    logic [PW-1:0]   post_count;
    logic            shutdown;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int unsigned m_lim [NCH];
    int unsigned m_cnt [NCH];
    bit          m_run [NCH];
    bit          m_exp [NCH];
    int          m_first;
    int          m_phase;
    int          m_pc;
    bit          m_sd;

    watchdog_multichannel #(
        .NUM_CHANNELS       (NCH),
        .COUNTER_WIDTH      (CW),
        .DEFAULT_TIMEOUT    (64'd40),
        .POST_COUNTER_WIDTH (PW),
        .POST_TIMEOUT       (PT)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .kick          (kick),
        .cfg_we        (cfg_we),
        .cfg_channel   (cfg_channel),
        .cfg_value     (cfg_value),
        .timeout_ack   (timeout_ack),
        .timeout       (timeout),
        .any_timeout   (any_timeout),
        .first_channel (first_channel),
        .post_count    (post_count),
        .shutdown      (shutdown)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        bit old_any;
        bit new_any;
        int lowest;
        old_any = 1'b0;
        for (int i = 0; i < NCH; i++) old_any |= m_exp[i];
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_lim[i] = DEF;
                m_cnt[i] = DEF;
                m_run[i] = 1'b0;
                m_exp[i] = 1'b0;
            end
            m_first = 0;
            m_phase = P_WAIT;
            m_pc    = PT;
            m_sd    = 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!enable[i]) begin
                    m_run[i] = 1'b0;
                    m_exp[i] = 1'b0;
                    m_cnt[i] = m_lim[i];
                end else if (m_exp[i]) begin
                    // expired channels ignore kicks
                end else if (!m_run[i]) begin
                    m_run[i] = 1'b1;
                    m_cnt[i] = m_lim[i];
                end else if (kick[i]) begin
                    m_cnt[i] = m_lim[i];
                end else if (m_cnt[i] > 0) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end else begin
                    m_run[i] = 1'b0;
                    m_exp[i] = 1'b1;
                end
            end
            // Write lands after the reloads above, so a same-edge kick saw the old limit
            if (cfg_we && (int'(cfg_channel) < NCH)) m_lim[cfg_channel] = cfg_value;

            new_any = 1'b0;
            lowest  = -1;
            for (int i = 0; i < NCH; i++) begin
                if (m_exp[i]) begin
                    new_any = 1'b1;
                    if (lowest < 0) lowest = i;
                end
            end
            if (!new_any)      m_first = 0;
            else if (!old_any) m_first = lowest;

            case (m_phase)
                P_WAIT:  if (old_any) m_phase = P_COUNT;
                P_COUNT: begin
                    if (!old_any) begin
                        m_phase = P_WAIT;
                        m_pc    = PT;
                    end else if (timeout_ack) begin
                        m_phase = P_ACKED;
                    end else if (m_pc == 0) begin
                        m_phase = P_DEAD;
                        m_sd    = 1'b1;
                    end else begin
                        m_pc = m_pc - 1;
                    end
                end
                P_ACKED: if (!old_any) begin
                    m_phase = P_WAIT;
                    m_pc    = PT;
                end
                default: ;
            endcase
        end
    endtask

    // One clock: step the model, let the edge happen, compare on the falling edge
    task automatic cycle();
        logic [NCH-1:0] exp_to;
        model_step();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NCH; i++) exp_to[i] = m_exp[i];
        chk("timeout",       64'(timeout),       64'(exp_to));
        chk("any_timeout",   64'(any_timeout),   64'(|exp_to));
        chk("first_channel", 64'(first_channel), 64'(m_first));
        chk("post_count",    64'(post_count),    64'(m_pc));
        chk("shutdown",      64'(shutdown),      64'(m_sd));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic write_limit(input int ch, input int val);
        cfg_we      = 1'b1;
        cfg_channel = CHW'(ch);
        cfg_value   = CW'(val);
        cycle();
        cfg_we      = 1'b0;
    endtask

    // Cycle until timeout[ch] rises or the budget runs out
    task automatic run_until(input int ch, input int maxc, output int n);
        n = 0;
        while (!timeout[ch] && n < maxc) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; enable = '0; kick = '0; cfg_we = 1'b0;
        cfg_channel = '0; cfg_value = '0; timeout_ack = 1'b0;
        @(negedge clk);
        do_reset();
        do_reset();
        chk("reset_post_count", 64'(post_count), 64'd4);
        chk("reset_timeout",    64'(timeout),    64'd0);

        // Limit 5, no kicks: expiry on the 7th edge, then unacked grace
        write_limit(0, 5);
        enable = 5'b00001;
        cycle();
        run_until(0, 20, n);
        chk("t0_expiry_edge", 64'(n + 1), 64'd7);
        chk("t0_first",       64'(first_channel), 64'd0);
        chk("t0_any",         64'(any_timeout),   64'd1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("grace_step", 64'(post_count), 64'(4 - k));
        end
        cycle();
        chk("shutdown_set", 64'(shutdown), 64'd1);
        enable = '0;
        cycle();
        chk("shutdown_sticky", 64'(shutdown), 64'd1);
        chk("t0_cleared",      64'(timeout),  64'd0);
        do_reset();
        chk("shutdown_reset",  64'(shutdown),   64'd0);
        chk("post_reset",      64'(post_count), 64'd4);

        // Channel 1, limit 10, regular kicks, then a kick on the zero edge
        write_limit(1, 10);
        enable = 5'b00010;
        cycle();
        for (int c = 0; c < 200; c++) begin
            kick[1] = (c % 8 == 7);
            cycle();
        end
        chk("kick8_no_expiry", 64'(timeout[1]), 64'd0);
        kick[1] = 1'b1;
        cycle();
        kick[1] = 1'b0;
        repeat (10) cycle();
        kick[1] = 1'b1;
        cycle();
        kick[1] = 1'b0;
        chk("kick_on_zero", 64'(timeout[1]), 64'd0);
        repeat (10) cycle();
        chk("pre_expiry", 64'(timeout[1]), 64'd0);
        cycle();
        chk("expiry_after_11", 64'(timeout[1]), 64'd1);
        enable = '0;
        cycle();
        do_reset();

        // Simultaneous expiry of 2 and 3, release, then 3 alone
        write_limit(2, 3);
        write_limit(3, 3);
        enable = 5'b01100;
        cycle();
        run_until(2, 20, n);
        chk("both_expired", 64'(timeout),       64'b01100);
        chk("first_is_2",   64'(first_channel), 64'd2);
        enable = '0;
        cycle();
        chk("cleared",        64'(timeout),       64'd0);
        chk("first_released", 64'(first_channel), 64'd0);
        cycle();
        enable = 5'b01000;
        cycle();
        run_until(3, 20, n);
        chk("first_is_3", 64'(first_channel), 64'd3);
        enable = '0;
        cycle();
        do_reset();

        // Ack on the post_count == 0 edge
        write_limit(0, 5);
        enable = 5'b00001;
        cycle();
        run_until(0, 20, n);
        repeat (5) cycle();
        chk("pc_zero", 64'(post_count), 64'd0);
        timeout_ack = 1'b1;
        cycle();
        timeout_ack = 1'b0;
        chk("ack_beats_zero", 64'(shutdown), 64'd0);
        repeat (3) cycle();
        chk("acked_no_shutdown", 64'(shutdown),   64'd0);
        chk("acked_pc_hold",     64'(post_count), 64'd0);
        enable = '0;
        cycle();
        cycle();
        chk("acked_reload", 64'(post_count), 64'd4);
        do_reset();

        // Mid-run limit change only applies at the next reload
        write_limit(0, 100);
        enable = 5'b00001;
        cycle();
        repeat (10) cycle();
        write_limit(0, 3);
        repeat (20) cycle();
        chk("midrun_unaffected", 64'(timeout[0]), 64'd0);
        kick[0] = 1'b1;
        cycle();
        kick[0] = 1'b0;
        run_until(0, 20, n);
        chk("new_limit_expiry", 64'(n), 64'd4);
        enable = '0;
        cycle();
        do_reset();

        // Out-of-range channel writes change nothing
        write_limit(7, 1);
        write_limit(5, 0);
        enable = 5'b11111;
        repeat (30) cycle();
        chk("oor_write_ignored", 64'(timeout), 64'd0);
        enable = '0;
        cycle();
        do_reset();

        // Randomized run
        for (int c = 0; c < 4000; c++) begin
            reset       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 24) == 0) enable = NCH'($urandom | $urandom);
            kick        = NCH'($urandom & $urandom & $urandom);
            cfg_we      = ($urandom_range(0, 7) == 0);
            cfg_channel = CHW'($urandom_range(0, 7));
            cfg_value   = CW'($urandom_range(0, 15));
            timeout_ack = ($urandom_range(0, 11) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "bench timed out");
    end

endmodule : tb_watchdog_multichannel

`default_nettype wire
